capsense_csd_measure_ch_acc: RTL and testbench
==============================================

// Module: capsense_csd_measure_ch_acc
// PURPOSE
//  Parametrised CSD measurement channel. Counts comparator-low pulses during a
//  programmable window of PRS/precharge pulses and accumulates NUM_SCANS
//  consecutive windows into one raw count. Sits between the precharge pulse
//  source, the sense comparator and the CPU interrupt/status path.
// PARAMETERS
//  CNT_W      16  raw count / result width, 8..32
//  WIN_W      16  window period width, 8..32
//  NUM_SCANS  1   windows accumulated per start, 1..16
//  CMP_INVERT 0   0: IDAC source (count cmp_in==0); 1: IDAC sink (cmp_in inverted first)
//  SATURATE   1   1: raw counter saturates at all-ones; 0: wraps modulo 2^CNT_W
// PORTS
//  clock          in   1      component clock
//  reset          in   1      asynchronous, active-high; clears all state
//  enable         in   1      clock enable; when 0, all registers hold
//  start          in   1      level request; rising level begins a measurement
//  pulse          in   1      one-cycle sample strobe, minimum spacing 2 cycles
//  cmp_in         in   1      sense comparator output, asynchronous to clock
//  window_period  in   WIN_W  pulses per window, sampled in LOAD
//  ioff           out  1      registered, polarity-adjusted comparator sample; drives IDAC gating
//  busy           out  1      1 in LOAD, WAIT and COUNT
//  interrupt      out  1      1 in DONE; held until start is low
//  raw_count      out  CNT_W  result register; updated only on completion
//  overflow       out  1      sticky; saturation or wrap occurred in the last completed measurement
// BEHAVIOUR
//  - Reset values: all outputs 0. State is IDLE; counters are 0.
//  - enable=0 freezes the FSM, counters and cmp sample. pulse is ignored on those cycles.
//  - cmp path: cmp_in goes through a 2-flop synchroniser, then an optional inversion.
//    The result is captured into cmp_q only on enabled cycles with pulse=1. ioff = cmp_q.
//  - FSM states: IDLE, LOAD, WAIT, COUNT, DONE.
//    IDLE:  start=1 -> LOAD. Clears acc, scan_idx and ovf.
//    LOAD:  win_cnt <= window_period, then -> WAIT. If window_period==0, -> COUNT-complete
//           path immediately: the window is zero-length and adds nothing to acc.
//    WAIT:  pulse=1 -> COUNT. cmp_q is captured on the same edge.
//    COUNT: one cycle. win_cnt <= win_cnt-1. If cmp_q==0, acc <= acc+1 (saturate or wrap per
//           SATURATE; ovf<=1 on either). The next state is chosen by the window count before
//           this decrement:
//             - win_cnt==1 and scan_idx==NUM_SCANS-1: raw_count<=acc (incl. this increment),
//               overflow<=ovf, -> DONE.
//             - win_cnt==1 and scans remain: scan_idx++, -> LOAD (acc kept).
//             - else -> WAIT.
//           A pulse arriving while in COUNT is ignored.
//    DONE:  interrupt=1. start=0 -> IDLE, else stay.
//  - Abort: start=0 in LOAD, WAIT or COUNT -> IDLE next enabled edge. No interrupt;
//    raw_count and overflow keep their previous values.
//  - Reset mid-operation: immediate return to IDLE with all outputs 0.
//  - Latency: the start edge gives LOAD at +1 cycle and WAIT at +2 cycles. Each window costs
//    window_period pulses plus one LOAD cycle. interrupt rises 1 cycle after the final COUNT.
//  - Widths: acc is CNT_W bits, win_cnt is WIN_W bits, scan_idx is 4 bits. No truncation
//    happens except at the saturation or wrap defined above.
// TESTING
//  1 NUM_SCANS=1, window_period=10, cmp_in=0 throughout, pulse every 4 cycles
//      -> raw_count=10, overflow=0, interrupt high 1 cycle after 10th COUNT.
//  2 window_period=8, cmp_in high for pulses 3..8 (after 2-flop sync)
//      -> raw_count=2; ioff=1 from pulse 3 on; CMP_INVERT=1 -> raw_count=6.
//  3 NUM_SCANS=4, window_period=5, cmp_in=0
//      -> raw_count=20; busy continuous from LOAD to DONE; 4 LOAD visits.
//  4 CNT_W=8, SATURATE=1, window_period=300, cmp_in=0
//      -> raw_count=8'hFF, overflow=1. With SATURATE=0 -> raw_count=8'h2C, overflow=1.
//  5 start dropped after 3 of 10 pulses, following a prior result of 10
//      -> IDLE, interrupt stays 0, raw_count stays 10. Async reset mid-WAIT -> all outputs 0 at once.
//  6 enable=0 for 20 cycles mid-window with pulses present -> counts unchanged.
//    window_period=0 -> DONE with raw_count=0.

Source files
------------

// File: rtl/capsense_csd_measure_ch_acc.sv
// CSD measurement channel with multi-window accumulation.
// Counts comparator-low samples taken on precharge pulses over a programmable
// window and sums NUM_SCANS consecutive windows into one raw count that is
// published to the CPU status path with an interrupt.
module capsense_csd_measure_ch_acc #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int NUM_SCANS  = 1,
  parameter int CMP_INVERT = 0,
  parameter int SATURATE   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             pulse,
  input  logic             cmp_in,
  input  logic [WIN_W-1:0] window_period,
  output logic             ioff,
  output logic             busy,
  output logic             interrupt,
  output logic [CNT_W-1:0] raw_count,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_COUNT,
    S_DONE
  } state_e;

  localparam logic       INV_BIT   = (CMP_INVERT != 0);
  localparam logic       SAT_BIT   = (SATURATE != 0);
  localparam logic [3:0] LAST_SCAN = 4'(NUM_SCANS - 1);

  // Comparator path
  logic sync1_q;
  logic sync2_q;
  logic cmp_q;

  // Measurement state
  state_e           state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] acc_q;
  logic [3:0]       scan_idx_q;
  logic             ovf_q;
  logic [CNT_W-1:0] raw_count_q;
  logic             overflow_q;
  logic             busy_q;
  logic             irq_q;

  // Next-state values for the accumulator and its overflow flag
  logic [CNT_W:0]   acc_sum;
  logic             acc_carry;
  logic [CNT_W-1:0] acc_d;
  logic             ovf_d;
  logic             last_scan;
  logic             win_last;

  assign acc_sum   = {1'b0, acc_q} + {{CNT_W{1'b0}}, 1'b1};
  assign acc_carry = acc_sum[CNT_W];
  assign last_scan = (scan_idx_q == LAST_SCAN);
  assign win_last  = (win_cnt_q == WIN_W'(1));

  // A sample of 0 (after polarity adjustment) adds one to the accumulator,
  // either clamping at all-ones or wrapping to zero on carry-out.
  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (!cmp_q) begin
      ovf_d = ovf_q | acc_carry;
      if (acc_carry && SAT_BIT) begin
        acc_d = {CNT_W{1'b1}};
      end else begin
        acc_d = acc_sum[CNT_W-1:0];
      end
    end
  end

  // Two-flop synchroniser on the comparator, then polarity fix and capture on pulse.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cmp_q   <= 1'b0;
    end else if (enable) begin
      sync1_q <= cmp_in;
      sync2_q <= sync1_q;
      if (pulse) begin
        cmp_q <= sync2_q ^ INV_BIT;
      end
    end
  end

  // Measurement FSM with window counter, accumulator and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      scan_idx_q  <= '0;
      ovf_q       <= 1'b0;
      raw_count_q <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q      <= '0;
            scan_idx_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (!start) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            win_cnt_q <= window_period;
            if (window_period == '0) begin
              // Zero-length window: completes at once and adds nothing.
              if (last_scan) begin
                raw_count_q <= acc_q;
                overflow_q  <= ovf_q;
                busy_q      <= 1'b0;
                irq_q       <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                scan_idx_q <= scan_idx_q + 4'd1;
                state_q    <= S_LOAD;
              end
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (!start) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (pulse) begin
            state_q <= S_COUNT;
          end
        end

        S_COUNT: begin
          if (!start) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            win_cnt_q <= win_cnt_q - WIN_W'(1);
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            if (win_last) begin
              if (last_scan) begin
                raw_count_q <= acc_d;
                overflow_q  <= ovf_d;
                busy_q      <= 1'b0;
                irq_q       <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                scan_idx_q <= scan_idx_q + 4'd1;
                state_q    <= S_LOAD;
              end
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_DONE: begin
          if (!start) begin
            irq_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          irq_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ioff      = cmp_q;
  assign busy      = busy_q;
  assign interrupt = irq_q;
  assign raw_count = raw_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_capsense_csd_measure_ch_acc.sv
// Directed bench for the CSD measurement channel. Five instances with
// different parameter sets share the stimulus; each scenario checks the
// instances it exercises against hand-computed results.
module tb_capsense_csd_measure_ch_acc;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        start;
  logic        pulse;
  logic        cmp_in;
  logic [15:0] window_period;

  // Default instance: CNT_W=16, NUM_SCANS=1, no inversion, saturating
  logic        a_ioff, a_busy, a_irq, a_ovf;
  logic [15:0] a_raw;
  // Inverted comparator polarity
  logic        i_ioff, i_busy, i_irq, i_ovf;
  logic [15:0] i_raw;
  // Four windows per measurement
  logic        m_ioff, m_busy, m_irq, m_ovf;
  logic [15:0] m_raw;
  // 8-bit saturating
  logic        s_ioff, s_busy, s_irq, s_ovf;
  logic [7:0]  s_raw;
  // 8-bit wrapping
  logic        w_ioff, w_busy, w_irq, w_ovf;
  logic [7:0]  w_raw;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_gaps = 0;
  logic mon_en = 1'b0;

  capsense_csd_measure_ch_acc u_dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .pulse(pulse),
    .cmp_in(cmp_in), .window_period(window_period), .ioff(a_ioff), .busy(a_busy),
    .interrupt(a_irq), .raw_count(a_raw), .overflow(a_ovf)
  );

  capsense_csd_measure_ch_acc #(.CMP_INVERT(1)) u_inv (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .pulse(pulse),
    .cmp_in(cmp_in), .window_period(window_period), .ioff(i_ioff), .busy(i_busy),
    .interrupt(i_irq), .raw_count(i_raw), .overflow(i_ovf)
  );

  capsense_csd_measure_ch_acc #(.NUM_SCANS(4)) u_ms (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .pulse(pulse),
    .cmp_in(cmp_in), .window_period(window_period), .ioff(m_ioff), .busy(m_busy),
    .interrupt(m_irq), .raw_count(m_raw), .overflow(m_ovf)
  );

  capsense_csd_measure_ch_acc #(.CNT_W(8), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .pulse(pulse),
    .cmp_in(cmp_in), .window_period(window_period), .ioff(s_ioff), .busy(s_busy),
    .interrupt(s_irq), .raw_count(s_raw), .overflow(s_ovf)
  );

  capsense_csd_measure_ch_acc #(.CNT_W(8), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .pulse(pulse),
    .cmp_in(cmp_in), .window_period(window_period), .ioff(w_ioff), .busy(w_busy),
    .interrupt(w_irq), .raw_count(w_raw), .overflow(w_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Busy must never drop while the multi-window measurement is running.
  always @(negedge clock) begin
    if (mon_en && !m_busy) busy_gaps++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Three idle cycles (lets a cmp_in change cross the synchroniser), then a
  // one-cycle pulse. Returns just after the edge that sampled the pulse.
  task automatic pulse_once();
    step();
    step();
    step();
    pulse = 1'b1;
    step();
    pulse = 1'b0;
  endtask

  // Time limit: the schedule below is fixed, so this only fires if the bench hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; pulse = 1'b0;
    cmp_in = 1'b0; window_period = 16'd0;
    step();
    step();

    // Reset state
    check("rst_raw",  32'(a_raw), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_irq",  32'(a_irq), 32'd0);
    check("rst_ioff", 32'(a_ioff), 32'd0);
    check("rst_ovf",  32'(a_ovf), 32'd0);
    reset = 1'b0;
    step();

    // 1: ten-pulse window, comparator low throughout
    window_period = 16'd10;
    cmp_in = 1'b0;
    start = 1'b1;
    step();
    check("t1_load_busy", 32'(a_busy), 32'd1);
    step();
    check("t1_wait_busy", 32'(a_busy), 32'd1);
    repeat (9) pulse_once();
    check("t1_raw_pending", 32'(a_raw), 32'd0);
    pulse_once();
    check("t1_irq_in_count", 32'(a_irq), 32'd0);
    step();
    check("t1_irq", 32'(a_irq), 32'd1);
    check("t1_busy_done", 32'(a_busy), 32'd0);
    check("t1_raw", 32'(a_raw), 32'd10);
    check("t1_ovf", 32'(a_ovf), 32'd0);
    step();
    check("t1_irq_held", 32'(a_irq), 32'd1);
    start = 1'b0;
    step();
    check("t1_irq_clear", 32'(a_irq), 32'd0);

    // 5a: abort after 3 of 10 pulses keeps the previous result
    start = 1'b1;
    step();
    step();
    repeat (3) pulse_once();
    start = 1'b0;
    step();
    check("abort_busy", 32'(a_busy), 32'd0);
    repeat (10) step();
    check("abort_irq", 32'(a_irq), 32'd0);
    check("abort_raw", 32'(a_raw), 32'd10);

    // 5b: asynchronous reset while waiting for a pulse
    cmp_in = 1'b1;
    start = 1'b1;
    step();
    step();
    pulse_once();
    step();
    check("pre_rst_ioff", 32'(a_ioff), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_raw",  32'(a_raw), 32'd0);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_ioff", 32'(a_ioff), 32'd0);
    check("mid_rst_irq",  32'(a_irq), 32'd0);
    start = 1'b0;
    cmp_in = 1'b0;
    step();
    reset = 1'b0;
    step();

    // 2: comparator high from pulse 3 on; normal and inverted polarity
    window_period = 16'd8;
    start = 1'b1;
    step();
    step();
    for (int i = 1; i <= 8; i++) begin
      cmp_in = (i >= 3);
      pulse_once();
      if (i == 2) check("t2_ioff_p2", 32'(a_ioff), 32'd0);
      if (i == 3) begin
        check("t2_ioff_p3", 32'(a_ioff), 32'd1);
        check("t2_inv_ioff_p3", 32'(i_ioff), 32'd0);
      end
    end
    step();
    check("t2_raw", 32'(a_raw), 32'd2);
    check("t2_inv_raw", 32'(i_raw), 32'd6);
    check("t2_irq", 32'(a_irq), 32'd1);
    check("t2_inv_irq", 32'(i_irq), 32'd1);
    start = 1'b0;
    cmp_in = 1'b0;
    step();

    // 3: four windows of five pulses
    window_period = 16'd5;
    start = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    repeat (19) pulse_once();
    check("t3_irq_pending", 32'(m_irq), 32'd0);
    check("t3_raw_pending", 32'(m_raw), 32'd0);
    pulse_once();
    mon_en = 1'b0;
    step();
    check("t3_busy_gaps", 32'(busy_gaps), 32'd0);
    check("t3_raw", 32'(m_raw), 32'd20);
    check("t3_irq", 32'(m_irq), 32'd1);
    check("t3_single_raw", 32'(a_raw), 32'd5);
    start = 1'b0;
    step();

    // 4: 300 counts into 8-bit counters
    window_period = 16'd300;
    start = 1'b1;
    step();
    step();
    repeat (300) pulse_once();
    step();
    check("t4_sat_raw", 32'(s_raw), 32'hFF);
    check("t4_sat_ovf", 32'(s_ovf), 32'd1);
    check("t4_wrap_raw", 32'(w_raw), 32'h2C);
    check("t4_wrap_ovf", 32'(w_ovf), 32'd1);
    check("t4_wide_raw", 32'(a_raw), 32'd300);
    check("t4_wide_ovf", 32'(a_ovf), 32'd0);
    start = 1'b0;
    step();

    // 6a: enable low for 20 cycles mid-window with pulses present
    window_period = 16'd4;
    start = 1'b1;
    step();
    step();
    pulse_once();
    pulse_once();
    step();
    enable = 1'b0;
    cmp_in = 1'b1;
    repeat (5) pulse_once();
    check("frz_irq", 32'(a_irq), 32'd0);
    check("frz_busy", 32'(a_busy), 32'd1);
    check("frz_ioff", 32'(a_ioff), 32'd0);
    check("frz_raw", 32'(a_raw), 32'd300);
    enable = 1'b1;
    cmp_in = 1'b0;
    pulse_once();
    pulse_once();
    step();
    check("frz_done_irq", 32'(a_irq), 32'd1);
    check("frz_done_raw", 32'(a_raw), 32'd4);
    check("frz_sat_raw", 32'(s_raw), 32'd4);
    check("frz_sat_ovf", 32'(s_ovf), 32'd0);
    start = 1'b0;
    step();

    // 6b: zero-length window completes with a zero count
    window_period = 16'd0;
    start = 1'b1;
    step();
    check("w0_load_busy", 32'(a_busy), 32'd1);
    step();
    check("w0_irq", 32'(a_irq), 32'd1);
    check("w0_raw", 32'(a_raw), 32'd0);
    check("w0_busy", 32'(a_busy), 32'd0);
    check("w0_ms_busy", 32'(m_busy), 32'd1);
    check("w0_ms_irq_pending", 32'(m_irq), 32'd0);
    step();
    step();
    step();
    check("w0_ms_irq", 32'(m_irq), 32'd1);
    check("w0_ms_raw", 32'(m_raw), 32'd0);
    start = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
